nios2_debug_cmd_sysclk_sync: RTL and testbench



---
 rtl/nios2_debug_cmd_sysclk_sync.sv | 119 +++++++++++
 tb/tb_nios2_debug_cmd_sysclk_sync.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_debug_cmd_sysclk_sync.sv
// System-clock side of the Nios II debug slave: synchronises the JTAG update strobes,
// captures each command atomically and presents it per channel with a held handshake.
module nios2_debug_cmd_sysclk_sync #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int ACT_BIT     = 35,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IR_WIDTH-1:0]      ir_in,
    input  logic [SR_WIDTH-1:0]      sr,
    input  logic                     vs_udr,
    input  logic                     vs_uir,
    input  logic [2**IR_WIDTH-1:0]   cmd_ready,
    output logic [SR_WIDTH-1:0]      jdo,
    output logic [2**IR_WIDTH-1:0]   cmd_valid,
    output logic [2**IR_WIDTH-1:0]   take_action,
    output logic [2**IR_WIDTH-1:0]   take_no_action,
    output logic                     overrun,
    output logic [CNT_WIDTH-1:0]     cmd_count
);

    localparam int NCH = 2**IR_WIDTH;

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    function automatic logic [NCH-1:0] onehot(input logic [IR_WIDTH-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
    logic                   udr_prev_q, uir_prev_q;
    logic                   udr_rise, uir_rise;

    state_t                 state_q;
    logic [SR_WIDTH-1:0]    jdo_q;
    logic [IR_WIDTH-1:0]    ch_q;
    logic [NCH-1:0]         valid_q, act_q, noact_q;
    logic                   ovr_q;
    logic [CNT_WIDTH-1:0]   cnt_q;

    logic                   accept, slot_free, capture, drop;

    // Flops preset to 1 so a strobe already high at reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync_q <= '1;
            uir_sync_q <= '1;
            udr_prev_q <= 1'b1;
            uir_prev_q <= 1'b1;
        end else begin
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
            uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
        end
    end

    assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
    assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;

    // The slot is free for a new capture if nothing is pending, or the pending
    // command is leaving this very cycle (accepted or aborted by update-IR).
    always_comb begin
        accept    = (state_q == PEND) && cmd_ready[ch_q];
        slot_free = (state_q == IDLE) || uir_rise || accept;
        capture   = udr_rise && slot_free;
        drop      = udr_rise && !slot_free;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            jdo_q   <= '0;
            ch_q    <= '0;
            valid_q <= '0;
            act_q   <= '0;
            noact_q <= '0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            act_q   <= '0;
            noact_q <= '0;

            if (accept && !uir_rise)
                cnt_q <= cnt_q + CNT_WIDTH'(1);

            if (uir_rise)
                ovr_q <= 1'b0;
            else if (drop)
                ovr_q <= 1'b1;

            if (capture) begin
                state_q <= PEND;
                jdo_q   <= sr;
                ch_q    <= ir_in;
                valid_q <= onehot(ir_in);
                if (sr[ACT_BIT])
                    act_q <= onehot(ir_in);
                else
                    noact_q <= onehot(ir_in);
            end else if (uir_rise || accept) begin
                state_q <= IDLE;
                valid_q <= '0;
            end
        end
    end

    assign jdo            = jdo_q;
    assign cmd_valid      = valid_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign overrun        = ovr_q;
    assign cmd_count      = cnt_q;

endmodule

// File: tb/tb_nios2_debug_cmd_sysclk_sync.sv
// Bench for nios2_debug_cmd_sysclk_sync: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_nios2_debug_cmd_sysclk_sync;

    localparam int SRW = 38;
    localparam int S   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      ir_in;
    logic [SRW-1:0]  sr;
    logic            vs_udr, vs_uir;
    logic [3:0]      cmd_ready;
    logic [SRW-1:0]  jdo;
    logic [3:0]      cmd_valid, take_action, take_no_action;
    logic            overrun;
    logic [7:0]      cmd_count;

    nios2_debug_cmd_sysclk_sync dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
        .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready),
        .jdo(jdo), .cmd_valid(cmd_valid), .take_action(take_action),
        .take_no_action(take_no_action), .overrun(overrun), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a pending-command slot plus a history of strobe samples.
    bit              udr_h[$];
    bit              uir_h[$];
    bit              m_pend;
    logic [1:0]      m_ch;
    logic [SRW-1:0]  m_jdo;
    logic [3:0]      m_ta, m_tn;
    bit              m_ovr;
    logic [7:0]      m_cnt;

    bit              rand_mode = 0;
    int              uir_left  = 0;

    task automatic mdl_reset();
        m_pend = 0; m_ch = '0; m_jdo = '0; m_ta = '0; m_tn = '0; m_ovr = 0; m_cnt = '0;
        udr_h.delete();
        uir_h.delete();
        repeat (S + 2) begin
            udr_h.push_front(1'b1);
            uir_h.push_front(1'b1);
        end
    endtask

    // An edge seen at the strobe input surfaces as an event S clock edges later.
    task automatic mdl_edge();
        bit urise, irise, acc;
        if (reset) begin
            mdl_reset();
        end else begin
            udr_h.push_front(vs_udr); void'(udr_h.pop_back());
            uir_h.push_front(vs_uir); void'(uir_h.pop_back());
            urise = udr_h[S] && !udr_h[S+1];
            irise = uir_h[S] && !uir_h[S+1];
            acc   = m_pend && cmd_ready[m_ch];
            m_ta = '0;
            m_tn = '0;
            if (irise) begin
                m_ovr  = 0;
                m_pend = 0;
            end else if (acc) begin
                m_cnt  = m_cnt + 8'd1;
                m_pend = 0;
            end
            if (urise) begin
                if (!m_pend) begin
                    m_pend = 1;
                    m_jdo  = sr;
                    m_ch   = ir_in;
                    if (sr[35]) m_ta = 4'b0001 << ir_in;
                    else        m_tn = 4'b0001 << ir_in;
                end else begin
                    m_ovr = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] ev;
        ev = m_pend ? (4'b0001 << m_ch) : 4'b0000;
        chk("jdo",            64'(jdo),            64'(m_jdo));
        chk("cmd_valid",      64'(cmd_valid),      64'(ev));
        chk("take_action",    64'(take_action),    64'(m_ta));
        chk("take_no_action", 64'(take_no_action), 64'(m_tn));
        chk("overrun",        64'(overrun),        64'(m_ovr));
        chk("cmd_count",      64'(cmd_count),      64'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        mdl_edge();
        #1;
        check_all();
        if (rand_mode) begin
            cmd_ready = 4'($urandom_range(0, 15));
            if (uir_left > 0) begin
                vs_uir = 1'b1;
                uir_left--;
            end else begin
                vs_uir = 1'b0;
                if ($urandom_range(0, 24) == 0) uir_left = 3;
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [SRW-1:0] d, input logic [1:0] ch, input int hi, input int lo);
        sr     = d;
        ir_in  = ch;
        vs_udr = 1'b1;
        steps(hi);
        vs_udr = 1'b0;
        steps(lo);
    endtask

    function automatic logic [SRW-1:0] rand_sr();
        return SRW'({$urandom, $urandom});
    endfunction

    logic [SRW-1:0] first_sr;

    initial begin
        reset = 1'b1; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = '0;
        mdl_reset();
        #2;
        chk("rst_jdo",   64'(jdo),       64'd0);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_count", 64'(cmd_count), 64'd0);
        steps(2);
        reset = 1'b0;
        steps(2);

        // Single action command on channel 1, consumer ready throughout.
        sr = 38'h8_0000_00AB; ir_in = 2'b01; cmd_ready = 4'b0010; vs_udr = 1'b1;
        steps(3);
        chk("t1_action", 64'(take_action), 64'h2);
        chk("t1_valid",  64'(cmd_valid),   64'h2);
        chk("t1_jdo",    64'(jdo),         64'h8_0000_00AB);
        step();
        chk("t1_count",  64'(cmd_count),   64'd1);
        vs_udr = 1'b0;
        steps(3);

        // No-action command on channel 0 held off by backpressure.
        cmd_ready = 4'b0000;
        send(rand_sr() & ~(38'h1 << 35), 2'b00, 4, 6);
        chk("t2_held", 64'(cmd_valid), 64'h1);
        cmd_ready = 4'b0001;
        step();
        cmd_ready = 4'b0000;
        step();
        chk("t2_count", 64'(cmd_count), 64'd2);

        // Overrun: second command while the first is still pending.
        first_sr = rand_sr();
        send(first_sr, 2'b10, 4, 3);
        send(rand_sr(), 2'b01, 4, 3);
        chk("t3_ovr", 64'(overrun), 64'd1);
        chk("t3_jdo", 64'(jdo),     64'(first_sr));
        vs_uir = 1'b1;
        steps(4);
        vs_uir = 1'b0;
        steps(2);
        chk("t3_ovr_clr", 64'(overrun),   64'd0);
        chk("t3_valid",   64'(cmd_valid), 64'd0);
        chk("t3_count",   64'(cmd_count), 64'd2);

        // Acceptance coincident with a new capture, channel 3 twice.
        send(rand_sr() | (38'h1 << 35), 2'b11, 4, 2);
        sr = rand_sr() & ~(38'h1 << 35); ir_in = 2'b11; vs_udr = 1'b1;
        first_sr = sr;
        steps(S);
        cmd_ready = 4'b1000;
        step();
        cmd_ready = 4'b0000;
        chk("t4_valid", 64'(cmd_valid),      64'h8);
        chk("t4_pulse", 64'(take_no_action), 64'h8);
        chk("t4_count", 64'(cmd_count),      64'd3);
        chk("t4_jdo",   64'(jdo),            64'(first_sr));
        steps(2);
        vs_udr = 1'b0;
        cmd_ready = 4'b1000;
        step();
        cmd_ready = 4'b0000;
        steps(2);

        // Asynchronous reset while pending, update-DR held high through release.
        sr = rand_sr(); ir_in = 2'b01; vs_udr = 1'b1;
        steps(4);
        #3;
        reset = 1'b1;
        mdl_reset();
        #1;
        chk("t5_valid", 64'(cmd_valid), 64'd0);
        chk("t5_jdo",   64'(jdo),       64'd0);
        chk("t5_count", 64'(cmd_count), 64'd0);
        chk("t5_ovr",   64'(overrun),   64'd0);
        steps(2);
        reset = 1'b0;
        steps(6);
        chk("t5_nocap", 64'(cmd_valid), 64'd0);
        vs_udr = 1'b0;
        steps(2);

        // Counter wrap after 256 accepted commands.
        cmd_ready = 4'b1111;
        for (int i = 0; i < 256; i++)
            send(rand_sr(), 2'($urandom_range(0, 3)), 4, 2);
        chk("t6_wrap", 64'(cmd_count), 64'd0);

        // Randomized traffic with random backpressure and update-IR pulses.
        rand_mode = 1;
        for (int i = 0; i < 300; i++)
            send(rand_sr(), 2'($urandom_range(0, 3)), $urandom_range(S + 1, S + 3), $urandom_range(1, 5));
        rand_mode = 0;
        vs_uir = 1'b0;
        cmd_ready = 4'b0000;
        steps(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
